// File: rtl/sequenciador_multiciclo_pkg.sv
// Shared constants and types for the multicycle sequencer.
// SEQUENCIADOR_INSTRUCAO_INVALIDA_EN adds the sticky INVALIDA state.
package sequenciador_multiciclo_pkg;

    localparam logic [6:0] OPC_CARGA       = 7'b0000011;
    localparam logic [6:0] OPC_ARMAZENA    = 7'b0100011;
    localparam logic [6:0] OPC_DESVIO      = 7'b1100011;
    localparam logic [6:0] OPC_IMEDIATO    = 7'b0010011;
    localparam logic [6:0] OPC_REGISTRADOR = 7'b0110011;

    localparam logic [2:0] F3_LH   = 3'b001;
    localparam logic [2:0] F3_SH   = 3'b001;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_ANDI = 3'b111;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_SUB  = 3'b000;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [3:0] ULA_ADD = 4'b0000;
    localparam logic [3:0] ULA_SUB = 4'b0001;
    localparam logic [3:0] ULA_AND = 4'b0010;
    localparam logic [3:0] ULA_OR  = 4'b0011;
    localparam logic [3:0] ULA_SRL = 4'b0100;

    localparam logic [1:0] IMM_I  = 2'b00;
    localparam logic [1:0] IMM_S  = 2'b01;
    localparam logic [1:0] IMM_SB = 2'b10;

    localparam logic [1:0] A_PC        = 2'b00;
    localparam logic [1:0] A_PC_ANTIGO = 2'b01;
    localparam logic [1:0] A_RS1       = 2'b10;

    localparam logic [1:0] B_RS2    = 2'b00;
    localparam logic [1:0] B_QUATRO = 2'b01;
    localparam logic [1:0] B_IMM    = 2'b10;

    localparam logic [1:0] WB_ULA = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4
`ifdef SEQUENCIADOR_INSTRUCAO_INVALIDA_EN
        , INVALIDA = 3'd5
`endif
    } estado_t;

    typedef struct packed {
        logic carga;
        logic armazena;
        logic desvio;
        logic op_imediato;
        logic op_registrador;
        logic legal;
    } classe_t;

endpackage

// File: rtl/sequenciador_multiciclo_if.sv
// Memory handshake between the sequencer (master) and the shared memory port (slave).
interface sequenciador_multiciclo_if;
    logic mem_requisicao;
    logic mem_escrever;
    logic endereco_fonte;
    logic mem_pronta;

    modport master (output mem_requisicao, output mem_escrever, output endereco_fonte,
                    input mem_pronta);
    modport slave  (input mem_requisicao, input mem_escrever, input endereco_fonte,
                    output mem_pronta);
endinterface

// File: rtl/sequenciador_multiciclo_classificador_instrucao.sv
// Combinational decode of opcode/funct3/funct7 into a one-hot class plus legal flag.
module classificador_instrucao
    import sequenciador_multiciclo_pkg::*;
(
    input  logic [6:0] codigo_operacao,
    input  logic [2:0] funcao3,
    input  logic [6:0] funcao7,
    output classe_t    classe
);

    always_comb begin
        classe = '0;
        case (codigo_operacao)
            OPC_CARGA:       classe.carga    = (funcao3 == F3_LH);
            OPC_ARMAZENA:    classe.armazena = (funcao3 == F3_SH);
            OPC_DESVIO:      classe.desvio   = (funcao3 == F3_BEQ);
            OPC_IMEDIATO:    classe.op_imediato = (funcao3 == F3_ANDI) || (funcao3 == F3_SRL);
            OPC_REGISTRADOR: classe.op_registrador =
                                 ((funcao3 == F3_SUB) && (funcao7 == F7_SUB)) || (funcao3 == F3_OR);
            default: ;
        endcase
        classe.legal = classe.carga | classe.armazena | classe.desvio |
                       classe.op_imediato | classe.op_registrador;
    end

endmodule

// File: rtl/sequenciador_multiciclo.sv
// Multicycle control FSM for the RV32 subset datapath with a shared memory port.
// SEQUENCIADOR_INSTRUCAO_INVALIDA_EN: illegal instructions trap in a sticky INVALIDA state.
module sequenciador_multiciclo
    import sequenciador_multiciclo_pkg::*;
#(
    parameter int unsigned LARGURA_CONTADOR = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [6:0]                  codigo_operacao,
    input  logic [2:0]                  funcao3,
    input  logic [6:0]                  funcao7,
    input  logic                        zero_ula,
    sequenciador_multiciclo_if.master   mem,
    output logic                        ir_escrever,
    output logic                        pc_escrever,
    output logic                        pc_fonte,
    output logic [1:0]                  ula_fonte_a,
    output logic [1:0]                  ula_fonte_b,
    output logic [3:0]                  operacao_ula,
    output logic [1:0]                  fonte_imediato,
    output logic                        escrever_registrador,
    output logic [1:0]                  memoria_para_registrador,
    output logic [2:0]                  estado,
    output logic [LARGURA_CONTADOR-1:0] instrucoes_concluidas
`ifdef SEQUENCIADOR_INSTRUCAO_INVALIDA_EN
    , output logic                      instrucao_invalida
`endif
);

    estado_t estado_q, estado_d;
    logic [LARGURA_CONTADOR-1:0] contador_q, contador_d;
    classe_t classe;
    logic requisicao, escrever_mem, endereco;

    classificador_instrucao u_classificador (
        .codigo_operacao (codigo_operacao),
        .funcao3         (funcao3),
        .funcao7         (funcao7),
        .classe          (classe)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= BUSCA;
            contador_q <= '0;
        end else begin
            estado_q   <= estado_d;
            contador_q <= contador_d;
        end
    end

    always_comb begin
        estado_d                 = estado_q;
        contador_d               = contador_q;
        requisicao               = 1'b0;
        escrever_mem             = 1'b0;
        endereco                 = 1'b0;
        ir_escrever              = 1'b0;
        pc_escrever              = 1'b0;
        pc_fonte                 = 1'b0;
        ula_fonte_a              = A_PC;
        ula_fonte_b              = B_RS2;
        operacao_ula             = ULA_ADD;
        fonte_imediato           = IMM_I;
        escrever_registrador     = 1'b0;
        memoria_para_registrador = WB_ULA;
        case (estado_q)
            BUSCA: begin
                requisicao = 1'b1;
                if (mem.mem_pronta) begin
                    ir_escrever = 1'b1;
                    pc_escrever = 1'b1;
                    ula_fonte_b = B_QUATRO;
                    estado_d    = DECODIFICA;
                end
            end
            DECODIFICA: begin
                ula_fonte_a    = A_PC_ANTIGO;
                ula_fonte_b    = B_IMM;
                fonte_imediato = IMM_SB;
`ifdef SEQUENCIADOR_INSTRUCAO_INVALIDA_EN
                estado_d = classe.legal ? EXECUTA : INVALIDA;
`else
                estado_d = classe.legal ? EXECUTA : BUSCA;
`endif
            end
            EXECUTA: begin
                ula_fonte_a = A_RS1;
                estado_d    = BUSCA;
                if (classe.carga || classe.armazena) begin
                    ula_fonte_b    = B_IMM;
                    fonte_imediato = classe.armazena ? IMM_S : IMM_I;
                    estado_d       = MEMORIA;
                end else if (classe.op_registrador) begin
                    operacao_ula = (funcao3 == F3_SUB) ? ULA_SUB : ULA_OR;
                    estado_d     = ESCRITA;
                end else if (classe.op_imediato) begin
                    ula_fonte_b  = B_IMM;
                    operacao_ula = (funcao3 == F3_ANDI) ? ULA_AND : ULA_SRL;
                    estado_d     = ESCRITA;
                end else begin
                    operacao_ula = ULA_SUB;
                    pc_escrever  = zero_ula;
                    pc_fonte     = zero_ula;
                    contador_d   = contador_q + LARGURA_CONTADOR'(1);
                end
            end
            MEMORIA: begin
                requisicao   = 1'b1;
                endereco     = 1'b1;
                escrever_mem = classe.armazena;
                if (mem.mem_pronta) begin
                    if (classe.armazena) begin
                        estado_d   = BUSCA;
                        contador_d = contador_q + LARGURA_CONTADOR'(1);
                    end else begin
                        estado_d = ESCRITA;
                    end
                end
            end
            ESCRITA: begin
                escrever_registrador     = 1'b1;
                memoria_para_registrador = classe.carga ? WB_MEM : WB_ULA;
                estado_d                 = BUSCA;
                contador_d               = contador_q + LARGURA_CONTADOR'(1);
            end
`ifdef SEQUENCIADOR_INSTRUCAO_INVALIDA_EN
            INVALIDA: estado_d = INVALIDA;
`endif
            default: estado_d = BUSCA;
        endcase
        // The async reset forces BUSCA immediately; keep the bus and enables quiet while it is held.
        if (reset) begin
            requisicao           = 1'b0;
            escrever_mem         = 1'b0;
            ir_escrever          = 1'b0;
            pc_escrever          = 1'b0;
            escrever_registrador = 1'b0;
        end
    end

    assign mem.mem_requisicao    = requisicao;
    assign mem.mem_escrever      = escrever_mem;
    assign mem.endereco_fonte    = endereco;
    assign estado                = estado_q;
    assign instrucoes_concluidas = contador_q;
`ifdef SEQUENCIADOR_INSTRUCAO_INVALIDA_EN
    assign instrucao_invalida    = (estado_q == INVALIDA);
`endif

endmodule

// File: doc/sequenciador_multiciclo.md
Name: sequenciador_multiciclo

Overview:
Multicycle control FSM for the RV32 subset datapath (lh, sh, sub, or, andi, srl, beq) sharing one memory port for instruction fetch and data access. It sequences fetch, decode, execute, memory and write-back. It drives all datapath mux, enable and ALU-operation signals, and handshakes with a variable-latency memory. It sits beside the register file, ALU and PC/IR registers, replacing single-cycle control.

Parameters:
LARGURA_CONTADOR, 32, width of the retired-instruction counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
codigo_operacao  in  7  opcode field of the IR
funcao3  in  3  funct3 field of the IR
funcao7  in  7  funct7 field of the IR
zero_ula  in  1  ALU zero flag, combinational from current ALU operands
mem_pronta  in  1  memory completes the access this cycle
mem_requisicao  out  1  memory access request
mem_escrever  out  1  request is a halfword store
endereco_fonte  out  1  memory address: 0=PC, 1=ALU result register
ir_escrever  out  1  load IR and pc_antigo from memory data and PC
pc_escrever  out  1  PC load enable
pc_fonte  out  1  PC source: 0=ALU output (PC+4), 1=ALU result register (branch target)
ula_fonte_a  out  2  00=PC, 01=pc_antigo, 10=rs1
ula_fonte_b  out  2  00=rs2, 01=constant 4, 10=immediate
operacao_ula  out  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 srl
fonte_imediato  out  2  00 I-type, 01 S-type, 10 SB-type
escrever_registrador  out  1  register-file write enable
memoria_para_registrador  out  2  write-back source: 00 ALU result register, 01 memory data
estado  out  3  current state, for debug
instrucoes_concluidas  out  LARGURA_CONTADOR  retired-instruction count

Behaviour:
- States and encodings: BUSCA=0, DECODIFICA=1, EXECUTA=2, MEMORIA=3, ESCRITA=4, INVALIDA=5 (exists only with the macro). All outputs are Moore/Mealy combinational from state, IR fields, zero_ula and mem_pronta. Unlisted outputs are 0.
- Reset (asynchronous): state=BUSCA, instrucoes_concluidas=0. mem_requisicao rises combinationally in BUSCA after reset release.
- BUSCA: mem_requisicao=1, endereco_fonte=0, held until mem_pronta. On the mem_pronta cycle: ir_escrever=1, pc_escrever=1, pc_fonte=0, ula_fonte_a=00, ula_fonte_b=01, operacao_ula=add; next state DECODIFICA. Zero-wait response (mem_pronta in the first request cycle) is legal.
- DECODIFICA: ula_fonte_a=01, ula_fonte_b=10, fonte_imediato=10, add (branch target latched into the ALU result register). Next state EXECUTA if the instruction is legal, else see Optional Feature.
- Legal instructions:
  - opcode 0000011 with f3=001 (lh)
  - opcode 0100011 with f3=001 (sh)
  - opcode 1100011 with f3=000 (beq)
  - opcode 0010011 with f3=111 (andi) or f3=101 (srl, funct7 ignored)
  - opcode 0110011 with f3=000 and f7=0100000 (sub), or f3=110 (or, funct7 ignored)
- EXECUTA:
  - lh/sh: a=rs1, b=imm, add, fonte_imediato 00/01; next state MEMORIA.
  - sub/or: a=rs1, b=rs2, op 0001/0011; next state ESCRITA.
  - andi/srl: a=rs1, b=imm, op 0010/0100; next state ESCRITA.
  - beq: a=rs1, b=rs2, sub. If zero_ula, pc_escrever=1 and pc_fonte=1. Next state BUSCA; instruction retires.
- MEMORIA: mem_requisicao=1, endereco_fonte=1, mem_escrever=1 for sh. Request and mem_escrever are held stable until mem_pronta. On mem_pronta, sh goes to BUSCA and retires; lh goes to ESCRITA.
- ESCRITA: escrever_registrador=1, memoria_para_registrador=01 for lh, else 00. Next state BUSCA; instruction retires.
- Latency, counted from the first BUSCA cycle with zero-wait memory: beq 3 cycles, sh 4, ALU ops 4, lh 5. Each memory wait cycle adds 1.
- Retire: instrucoes_concluidas increments by 1 in the retiring cycle and wraps to 0 at 2^LARGURA_CONTADOR.
- mem_pronta outside BUSCA/MEMORIA is ignored.
- Reset asserted mid-access drops mem_requisicao immediately; no write is issued after reset.

Optional Feature:
SEQUENCIADOR_INSTRUCAO_INVALIDA_EN.
- Defined: an illegal instruction in DECODIFICA goes to INVALIDA. INVALIDA is sticky until reset, has all enables 0, and asserts extra output instrucao_invalida=1.
- Undefined: an illegal instruction goes DECODIFICA→BUSCA as a NOP. It is not counted, and the instrucao_invalida port is absent.

Decomposition:
- Shared package holds: opcode constants, funct3/funct7 constants, operacao_ula codes, fonte_imediato codes, ula_fonte_a/b codes, and state encodings.
- One natural sub-module: classificador_instrucao, combinational. It maps opcode/funct3/funct7 to a one-hot class (carga, armazena, desvio, op_imediato, op_registrador) plus a legal flag.

Test Plan:
- sub (f7=0100000, f3=000, op=0110011), zero-wait memory → states 0,1,2,4,0. escrever_registrador=1 only in cycle 4, operacao_ula=0001 in EXECUTA. Counter 0→1.
- lh (op=0000011, f3=001), mem_pronta delayed 3 cycles in MEMORIA → endereco_fonte=1 and mem_requisicao held 4 cycles. ESCRITA has memoria_para_registrador=01. Total 8 cycles.
- beq with zero_ula=1 → pc_escrever=1 and pc_fonte=1 in EXECUTA. With zero_ula=0 → pc_escrever=0. Both return to BUSCA after 3 cycles.
- sh with mem_pronta=0 for 5 cycles, then reset asserted → mem_requisicao drops same cycle. State=0, counter=0, no mem_escrever after reset.
- op=0110011 f3=000 f7=0000000 → without macro: back to BUSCA, counter unchanged. With macro: estado=5, instrucao_invalida=1 until reset.
- LARGURA_CONTADOR=2, five or instructions → counter sequence 1,2,3,0,1.
